cmos_sync_decoder: RTL

Word-alignment and sync-code decoder placed directly downstream of the LVDS deserializer. It takes the four 20-bit data windows and the 20-bit sync-channel window, together with a strobe that marks each new 10-bit word period. It first trains the 10-bit word boundary on the sensor training pattern. It then decodes the sync channel into frame and line framing and emits a 40-bit, 4-pixel-wide stream toward the frame buffer/DDR3 write path.

---
 rtl/cmos_sync_decoder_if.sv | 40 ++++
 rtl/cmos_sync_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_sync_decoder_if.sv
// Deserializer-side bus for cmos_sync_decoder: raw lane windows in, aligned pixel stream and framing out.
// Stats ports exist only when CMOS_SYNC_STATS_EN is defined.
interface cmos_sync_decoder_if;
  logic        raw_valid;
  logic [19:0] ch0_raw;
  logic [19:0] ch1_raw;
  logic [19:0] ch2_raw;
  logic [19:0] ch3_raw;
  logic [19:0] sync_raw;
  logic        locked;
  logic [3:0]  bit_offset;
  logic [39:0] pix_data;
  logic        pix_valid;
  logic        sof;
  logic        eol;
  logic        eof;
  logic [15:0] frame_cnt;
  logic        lost_lock;
`ifdef CMOS_SYNC_STATS_EN
  logic [15:0] line_cnt;
  logic [15:0] px_per_line;
  logic        len_err;
`endif

  modport master (
    output raw_valid, ch0_raw, ch1_raw, ch2_raw, ch3_raw, sync_raw,
`ifdef CMOS_SYNC_STATS_EN
    input  line_cnt, px_per_line, len_err,
`endif
    input  locked, bit_offset, pix_data, pix_valid, sof, eol, eof, frame_cnt, lost_lock
  );

  modport slave (
    input  raw_valid, ch0_raw, ch1_raw, ch2_raw, ch3_raw, sync_raw,
`ifdef CMOS_SYNC_STATS_EN
    output line_cnt, px_per_line, len_err,
`endif
    output locked, bit_offset, pix_data, pix_valid, sof, eol, eof, frame_cnt, lost_lock
  );
endinterface

// File: rtl/cmos_sync_decoder.sv
// Word-boundary trainer and sync-code decoder for the 4-lane CMOS LVDS stream.
// Optional per-line statistics (line_cnt, px_per_line, len_err) under CMOS_SYNC_STATS_EN.
module cmos_sync_decoder #(
  parameter logic [9:0] TRAIN_CODE = 10'h3A6,
  parameter logic [9:0] CODE_FS    = 10'h2AA,
  parameter logic [9:0] CODE_LS    = 10'h0AA,
  parameter logic [9:0] CODE_IMG   = 10'h035,
  parameter logic [9:0] CODE_LE    = 10'h12A,
  parameter logic [9:0] CODE_FE    = 10'h32A,
  parameter int         LOCK_COUNT = 16,
  parameter int         MAX_BAD    = 8
) (
  input  logic               clk_input,
  input  logic               rst_n,
  cmos_sync_decoder_if.slave bus
);

  localparam logic [1:0]  ST_SEARCH = 2'd0;
  localparam logic [1:0]  ST_VERIFY = 2'd1;
  localparam logic [1:0]  ST_LOCKED = 2'd2;
  localparam logic [15:0] LOCK_N    = 16'(LOCK_COUNT);
  localparam logic [15:0] BAD_N     = 16'(MAX_BAD);

  function automatic logic [9:0] slice_word(input logic [19:0] raw, input logic [3:0] off);
    logic [19:0] shifted;
    shifted = raw >> off;
    return shifted[9:0];
  endfunction

  logic [1:0]  state;
  logic [3:0]  k;
  logic [15:0] match_cnt;
  logic [15:0] bad_cnt;
  logic        in_frame;
  logic        in_line;
  logic        sof_arm;
  logic        locked_p1;
  logic        vld_p1;
  logic        sof_p1;
  logic        eol_p1;
  logic        eof_p1;
  logic        lost_p1;
  logic [39:0] pix_data_p1;
  logic [15:0] frame_cnt_p1;

  // Stage p0: slice all lanes at the current offset and classify the sync word
  logic [9:0]  sync_word_p0;
  logic [39:0] pix_word_p0;
  logic [3:0]  next_k;
  logic        lk_p0;
  logic        is_train;
  logic        is_fs;
  logic        is_ls;
  logic        is_img;
  logic        is_le;
  logic        is_fe;
  logic        take_fs;
  logic        take_ls;
  logic        take_img;
  logic        take_le;

  assign sync_word_p0 = slice_word(bus.sync_raw, k);
  assign pix_word_p0  = {slice_word(bus.ch3_raw, k), slice_word(bus.ch2_raw, k),
                         slice_word(bus.ch1_raw, k), slice_word(bus.ch0_raw, k)};
  assign next_k       = (k == 4'd9) ? 4'd0 : k + 4'd1;
  assign lk_p0        = bus.raw_valid && (state == ST_LOCKED);
  assign is_train     = (sync_word_p0 == TRAIN_CODE);
  assign is_fs        = (sync_word_p0 == CODE_FS);
  assign is_ls        = (sync_word_p0 == CODE_LS);
  assign is_img       = (sync_word_p0 == CODE_IMG);
  assign is_le        = (sync_word_p0 == CODE_LE);
  assign is_fe        = (sync_word_p0 == CODE_FE);
  assign take_fs      = lk_p0 && is_fs;
  assign take_ls      = lk_p0 && is_ls && in_frame;
  assign take_img     = lk_p0 && is_img && in_line;
  assign take_le      = lk_p0 && is_le;

  // Stage p1: registered FSM state, framing flags and output pulses
  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SEARCH;
      k            <= 4'd0;
      match_cnt    <= 16'd0;
      bad_cnt      <= 16'd0;
      in_frame     <= 1'b0;
      in_line      <= 1'b0;
      sof_arm      <= 1'b0;
      locked_p1    <= 1'b0;
      vld_p1       <= 1'b0;
      sof_p1       <= 1'b0;
      eol_p1       <= 1'b0;
      eof_p1       <= 1'b0;
      lost_p1      <= 1'b0;
      pix_data_p1  <= 40'd0;
      frame_cnt_p1 <= 16'd0;
    end else begin
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      eof_p1  <= 1'b0;
      lost_p1 <= 1'b0;
      if (bus.raw_valid) begin
        case (state)
          ST_SEARCH: begin
            if (is_train) begin
              if (LOCK_N <= 16'd1) begin
                state     <= ST_LOCKED;
                locked_p1 <= 1'b1;
                bad_cnt   <= 16'd0;
              end else begin
                state     <= ST_VERIFY;
                match_cnt <= 16'd1;
              end
            end else begin
              k <= next_k;
            end
          end
          ST_VERIFY: begin
            if (is_train) begin
              if (match_cnt + 16'd1 >= LOCK_N) begin
                state     <= ST_LOCKED;
                locked_p1 <= 1'b1;
                match_cnt <= 16'd0;
                bad_cnt   <= 16'd0;
              end else begin
                match_cnt <= match_cnt + 16'd1;
              end
            end else begin
              state     <= ST_SEARCH;
              match_cnt <= 16'd0;
              k         <= next_k;
            end
          end
          ST_LOCKED: begin
            bad_cnt <= 16'd0;
            if (is_fs) begin
              in_frame <= 1'b1;
              in_line  <= 1'b1;
              sof_arm  <= 1'b1;
            end else if (is_ls) begin
              if (in_frame) in_line <= 1'b1;
            end else if (is_img) begin
              if (in_line) begin
                vld_p1      <= 1'b1;
                pix_data_p1 <= pix_word_p0;
                sof_p1      <= sof_arm;
                sof_arm     <= 1'b0;
              end
            end else if (is_le) begin
              in_line <= 1'b0;
              eol_p1  <= 1'b1;
            end else if (is_fe) begin
              in_frame     <= 1'b0;
              in_line      <= 1'b0;
              sof_arm      <= 1'b0;
              eof_p1       <= 1'b1;
              frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
            end else if (!is_train) begin
              // Unknown code: tolerate a short burst before declaring the boundary lost
              if (bad_cnt + 16'd1 >= BAD_N) begin
                state     <= ST_SEARCH;
                locked_p1 <= 1'b0;
                in_frame  <= 1'b0;
                in_line   <= 1'b0;
                sof_arm   <= 1'b0;
                lost_p1   <= 1'b1;
              end else begin
                bad_cnt <= bad_cnt + 16'd1;
              end
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.locked     = locked_p1;
  assign bus.bit_offset = k;
  assign bus.pix_data   = pix_data_p1;
  assign bus.pix_valid  = vld_p1;
  assign bus.sof        = sof_p1;
  assign bus.eol        = eol_p1;
  assign bus.eof        = eof_p1;
  assign bus.frame_cnt  = frame_cnt_p1;
  assign bus.lost_lock  = lost_p1;

`ifdef CMOS_SYNC_STATS_EN
  logic [15:0] line_cnt_p1;
  logic [15:0] px_per_line_p1;
  logic        len_err_p1;
  logic [15:0] px_cnt;

  // Stage p1 stats: IMG words per line, compared against the previous line of the same frame
  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_p1    <= 16'd0;
      px_per_line_p1 <= 16'd0;
      len_err_p1     <= 1'b0;
      px_cnt         <= 16'd0;
    end else if (take_fs) begin
      line_cnt_p1 <= 16'd0;
      px_cnt      <= 16'd0;
    end else if (take_ls) begin
      px_cnt <= 16'd0;
    end else if (take_img) begin
      px_cnt <= px_cnt + 16'd1;
    end else if (take_le) begin
      px_per_line_p1 <= px_cnt;
      line_cnt_p1    <= line_cnt_p1 + 16'd1;
      px_cnt         <= 16'd0;
      if (line_cnt_p1 != 16'd0 && px_cnt != px_per_line_p1) len_err_p1 <= 1'b1;
    end
  end

  assign bus.line_cnt    = line_cnt_p1;
  assign bus.px_per_line = px_per_line_p1;
  assign bus.len_err     = len_err_p1;
`endif

endmodule
